// File: rtl/jtcop_disp_arb.sv
// Display-bus arbiter between CPU accesses and object DMA. The CPU gets the bus
// during blanking only; the object DMA takes priority and copies 2^DMA_AW words.
module jtcop_disp_arb #(
  parameter int unsigned DMA_AW  = 10,
  parameter int unsigned ACK_DLY = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_cen,
  input  logic              disp_cs,
  input  logic              LVBL,
  input  logic              LHBL,
  input  logic              dma_start,
  output logic              disp_busy,
  output logic              dma_busy,
  output logic [DMA_AW-1:0] dma_addr,
  output logic              dma_we,
  output logic              dma_done,
  output logic [2:0]        st
);

  localparam int unsigned CntW = $clog2(ACK_DLY + 2);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCpuWait = 3'd1,
    StCpuAck  = 3'd2,
    StCpuHold = 3'd3,
    StDma     = 3'd4
  } state_e;

  state_e            state_q;
  logic              cs_l_q;
  logic              pend_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              dma_busy_q;
  logic              dma_we_q;
  logic              dma_done_q;
  logic [DMA_AW-1:0] dma_addr_q;

  logic blank;
  logic cs_rise;
  logic dma_req;
  logic addr_last;

  assign blank     = ~LVBL | ~LHBL;
  assign cs_rise   = disp_cs & ~cs_l_q;
  assign dma_req   = pend_q | dma_start;
  assign addr_last = (dma_addr_q == {DMA_AW{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cs_l_q     <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      dma_busy_q <= 1'b0;
      dma_we_q   <= 1'b0;
      dma_done_q <= 1'b0;
      dma_addr_q <= '0;
    end else begin
      cs_l_q     <= disp_cs;
      dma_done_q <= 1'b0;
      // Requests arriving while the copy runs are dropped, not queued.
      if (dma_start && state_q != StDma) pend_q <= 1'b1;
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (dma_req) begin
            state_q    <= StDma;
            pend_q     <= 1'b0;
            busy_q     <= cs_rise;
            dma_busy_q <= 1'b1;
            dma_we_q   <= 1'b1;
            dma_addr_q <= '0;
          end else if (cs_rise) begin
            state_q <= StCpuWait;
            busy_q  <= 1'b1;
          end
        end
        StCpuWait: begin
          if (!disp_cs) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (blank) begin
            state_q <= StCpuAck;
            cnt_q   <= CntW'(ACK_DLY);
          end
        end
        StCpuAck: begin
          // Once granted, the access completes even if blanking ends.
          if (!disp_cs) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= StCpuHold;
            busy_q  <= 1'b0;
          end else if (cpu_cen) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
              state_q <= StCpuHold;
              busy_q  <= 1'b0;
            end
          end
        end
        StCpuHold: begin
          busy_q <= 1'b0;
          if (!disp_cs) begin
            if (dma_req) begin
              state_q    <= StDma;
              pend_q     <= 1'b0;
              dma_busy_q <= 1'b1;
              dma_we_q   <= 1'b1;
              dma_addr_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDma: begin
          busy_q <= disp_cs & (busy_q | cs_rise);
          if (addr_last) begin
            dma_busy_q <= 1'b0;
            dma_we_q   <= 1'b0;
            dma_done_q <= 1'b1;
            if (disp_cs && (busy_q || cs_rise)) begin
              state_q <= StCpuWait;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            dma_addr_q <= dma_addr_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          dma_busy_q <= 1'b0;
          dma_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign disp_busy = busy_q;
  assign dma_busy  = dma_busy_q;
  assign dma_addr  = dma_addr_q;
  assign dma_we    = dma_we_q;
  assign dma_done  = dma_done_q;
  assign st        = state_q;

endmodule
